inv_add_round_key: RTL and testbench

- Decryption-path stage directly downstream of the inverse-substitution stage.
- Accepts one 132-bit state word: a 4-bit round header plus a 128-bit AES state.
- Fetches that round's 128-bit key from the key-schedule store over a request/acknowledge port, XORs it into the state 32 bits at a time and presents the result under a valid/ready handshake.
- Header-0 bubbles and out-of-range rounds are filtered here so they never reach the next stage.

---
 rtl/inv_add_round_key.sv | 202 ++++++++++++++++++++
 tb/tb_inv_add_round_key.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_add_round_key.sv
`default_nettype none
// ============================================================================
//  Module      : inv_add_round_key
//  Description : Decryption-path AddRoundKey stage. Captures a {header, state}
//                word, fetches the matching round key over a req/ack port,
//                XORs it into the state WORDS_PER_CYCLE 32-bit words per cycle
//                and offers {header, state ^ key} under valid/ready.
//                Header-0 bubbles are dropped silently; headers above
//                NUM_ROUNDS are dropped with a one-cycle key_err pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module inv_add_round_key #(
    parameter int WORDS_PER_CYCLE = 1,   // legal: 1, 2, 4
    parameter int NUM_ROUNDS      = 10,  // highest legal header value
    parameter int KEY_TIMEOUT     = 16   // KEY_WAIT cycles before abort
) (
    input  logic         clk,
    input  logic         rst,
    // upstream word
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic [131:0] i_in_data,
    // key-schedule store port
    output logic         o_key_req,
    output logic [3:0]   o_key_round,
    input  logic         i_key_ack,
    input  logic [127:0] i_key_data,
    // downstream word
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [131:0] o_out_data,
    // error pulse
    output logic         o_key_err
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // Number of XOR cycles needed to cover the four state words.
    localparam int               c_GROUPS   = 4 / WORDS_PER_CYCLE;
    localparam logic [1:0]       c_LAST_GRP = 2'(c_GROUPS - 1);
    // Timeout counter only has to reach KEY_TIMEOUT-1.
    localparam int               c_TO_W     = (KEY_TIMEOUT > 1) ? $clog2(KEY_TIMEOUT) : 1;
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(KEY_TIMEOUT - 1);
    localparam logic [c_TO_W-1:0] c_TO_ONE  = c_TO_W'(1);
    localparam logic [3:0]       c_MAX_HDR  = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_KEY_WAIT = 2'd1,
        S_XOR      = 2'd2,
        S_OUT      = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [3:0]          r_hdr;
    logic [127:0]        r_data;
    logic [127:0]        r_key;
    logic [1:0]          r_word_cnt;
    logic [c_TO_W-1:0]   r_to_cnt;

    logic                r_in_ready;
    logic                r_key_req;
    logic [3:0]          r_key_round;
    logic                r_out_valid;
    logic [131:0]        r_out_data;
    logic                r_key_err;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [3:0]   w_in_hdr;
    logic         w_hdr_zero;
    logic         w_hdr_bad;
    logic         w_last_grp;
    logic [127:0] w_xor_next;

    assign w_in_hdr   = i_in_data[131:128];
    assign w_hdr_zero = (w_in_hdr == 4'd0);
    assign w_hdr_bad  = (w_in_hdr > c_MAX_HDR);
    assign w_last_grp = (r_word_cnt == c_LAST_GRP);

    // Word k (k=0 is bits [127:96]) belongs to XOR group k/WORDS_PER_CYCLE,
    // so the MSB word is always processed first.
    for (genvar k = 0; k < 4; k++) begin : g_word
        localparam logic [1:0] c_GRP = 2'(k / WORDS_PER_CYCLE);
        logic w_sel;
        assign w_sel = (r_word_cnt == c_GRP);
        assign w_xor_next[127-32*k -: 32] = w_sel
            ? (r_data[127-32*k -: 32] ^ r_key[127-32*k -: 32])
            :  r_data[127-32*k -: 32];
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered outputs. Every output is updated on the
    // same edge as the state it belongs to, so no output decode is needed.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_hdr       <= 4'd0;
            r_data      <= 128'd0;
            r_key       <= 128'd0;
            r_word_cnt  <= 2'd0;
            r_to_cnt    <= '0;
            r_in_ready  <= 1'b1;
            r_key_req   <= 1'b0;
            r_key_round <= 4'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 132'd0;
            r_key_err   <= 1'b0;
        end else begin
            // key_err is a single-cycle pulse unless re-armed below
            r_key_err <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_hdr  <= w_in_hdr;
                        r_data <= i_in_data[127:0];
                        if (w_hdr_zero) begin
                            // bubble: nothing to do, remain ready
                            r_state <= S_IDLE;
                        end else if (w_hdr_bad) begin
                            // no such round key exists; flag and drop
                            r_key_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state     <= S_KEY_WAIT;
                            r_in_ready  <= 1'b0;
                            r_key_req   <= 1'b1;
                            r_key_round <= w_in_hdr;
                            r_to_cnt    <= '0;
                        end
                    end
                end

                S_KEY_WAIT: begin
                    if (i_key_ack) begin
                        // an ack on the final timeout cycle still wins
                        r_key      <= i_key_data;
                        r_to_cnt   <= '0;
                        r_key_req  <= 1'b0;
                        r_word_cnt <= 2'd0;
                        r_state    <= S_XOR;
                    end else if (r_to_cnt == c_TO_LAST) begin
                        // key store never answered: abort and drop the word
                        r_key_err  <= 1'b1;
                        r_key_req  <= 1'b0;
                        r_to_cnt   <= '0;
                        r_in_ready <= 1'b1;
                        r_state    <= S_IDLE;
                    end else begin
                        r_to_cnt <= r_to_cnt + c_TO_ONE;
                    end
                end

                S_XOR: begin
                    r_data <= w_xor_next;
                    if (w_last_grp) begin
                        // load the output directly from the final XOR result
                        r_word_cnt  <= 2'd0;
                        r_out_valid <= 1'b1;
                        r_out_data  <= {r_hdr, w_xor_next};
                        r_state     <= S_OUT;
                    end else begin
                        r_word_cnt <= r_word_cnt + 2'd1;
                    end
                end

                S_OUT: begin
                    // out_data is simply held until the consumer takes it
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_data  <= 132'd0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_in_ready  = r_in_ready;
    assign o_key_req   = r_key_req;
    assign o_key_round = r_key_round;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_key_err   = r_key_err;

endmodule
`default_nettype wire

// File: tb/tb_inv_add_round_key.sv
`default_nettype none
// ============================================================================
//  Module      : tb_inv_add_round_key
//  Description : Scoreboard bench for inv_add_round_key. Instance 0 uses one
//                word per cycle, instance 1 four words per cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_inv_add_round_key;

    localparam int NR = 10;
    localparam int KT = 16;

    typedef struct {
        logic [131:0] data;
        int           first_cyc;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [131:0] in_data   [2];
    logic         key_req   [2];
    logic [3:0]   key_round [2];
    logic         key_ack   [2];
    logic [127:0] key_data  [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [131:0] out_data  [2];
    logic         key_err   [2];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t sb [2][$];
    int   err_cnt [2];
    int   req_cnt [2];
    int   err_cyc [2];
    int   hs_cyc  [2];
    int   exp_err [2];
    logic         prev_valid [2];
    logic         prev_ready [2];
    logic [131:0] prev_data  [2];
    bit   rand_rdy = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        inv_add_round_key #(
            .WORDS_PER_CYCLE ((g == 0) ? 1 : 4),
            .NUM_ROUNDS      (NR),
            .KEY_TIMEOUT     (KT)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .i_in_valid  (in_valid[g]),
            .o_in_ready  (in_ready[g]),
            .i_in_data   (in_data[g]),
            .o_key_req   (key_req[g]),
            .o_key_round (key_round[g]),
            .i_key_ack   (key_ack[g]),
            .i_key_data  (key_data[g]),
            .o_out_valid (out_valid[g]),
            .i_out_ready (out_ready[g]),
            .o_out_data  (out_data[g]),
            .o_key_err   (key_err[g])
        );
    end

    task automatic chk(input string name, input logic [131:0] act, input logic [131:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops the scoreboard on each transfer, checks first-valid
    // latency, hold-under-backpressure, and zero data while not valid.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                prev_valid[i] = 1'b0;
                prev_ready[i] = 1'b0;
            end else begin
                if (key_err[i]) begin
                    err_cnt[i]++;
                    err_cyc[i] = cyc;
                end
                if (key_req[i]) req_cnt[i]++;
                if (!out_valid[i]) begin
                    chk("idle_data_zero", out_data[i], '0);
                end else begin
                    if (!prev_valid[i]) begin
                        if (sb[i].size() == 0) begin
                            n_cmp++;
                            n_err++;
                            $display("FAIL unexpected_out dut%0d: got %h, expected no output", i, out_data[i]);
                        end else if (sb[i][0].first_cyc >= 0) begin
                            chk("first_valid_cycle", 132'(cyc), 132'(sb[i][0].first_cyc));
                        end
                    end else if (!prev_ready[i]) begin
                        chk("hold_stable", out_data[i], prev_data[i]);
                    end
                    if (out_ready[i] && sb[i].size() != 0) begin
                        e = sb[i].pop_front();
                        chk("out_data", out_data[i], e.data);
                        hs_cyc[i] = cyc;
                    end
                end
                prev_valid[i] = out_valid[i];
                prev_ready[i] = out_ready[i];
                prev_data[i]  = out_data[i];
            end
        end
    end

    // Random backpressure during the random phase only
    always @(posedge clk) begin
        #1;
        if (rand_rdy) begin
            for (int i = 0; i < 2; i++) out_ready[i] = ($urandom_range(0, 3) != 0);
        end
    end

    // Issue one word; the reference result is simply {hdr, state ^ key} for
    // legal headers and nothing otherwise. ack_dly < 0 means never acknowledge.
    task automatic send(input int i, input logic [3:0] hdr, input logic [127:0] st,
                        input logic [127:0] key, input int ack_dly, input bit wait_done,
                        output int acc);
        int   g;
        int   n;
        bit   legal;
        exp_t e;
        n     = (i == 0) ? 4 : 1;
        legal = (hdr != 4'd0) && (int'(hdr) <= NR);
        g = 0;
        while (!in_ready[i] && g < 300) begin
            step(1);
            g++;
        end
        if (!in_ready[i]) begin
            n_cmp++;
            n_err++;
            $display("FAIL accept_wait dut%0d: in_ready 0, expected 1", i);
        end
        in_valid[i] = 1'b1;
        in_data[i]  = {hdr, st};
        acc = cyc + 1;
        if (legal && ack_dly >= 0) begin
            e.data      = {hdr, st ^ key};
            e.first_cyc = acc + 1 + ack_dly + n;
            sb[i].push_back(e);
        end
        if (int'(hdr) > NR || (legal && ack_dly < 0)) exp_err[i]++;
        step(1);
        in_valid[i] = 1'b0;
        in_data[i]  = {4'h0, rnd128()};
        if (legal) begin
            chk("key_req", 132'(key_req[i]), 132'(1));
            chk("key_round", 132'(key_round[i]), 132'(hdr));
            if (ack_dly >= 0) begin
                step(ack_dly);
                key_ack[i]  = 1'b1;
                key_data[i] = key;
                step(1);
                key_ack[i]  = 1'b0;
                key_data[i] = rnd128();
                // a stray ack after the key is taken must be ignored
                if ($urandom_range(0, 1) == 1) begin
                    key_ack[i] = 1'b1;
                    step(1);
                    key_ack[i] = 1'b0;
                end
            end
        end else begin
            chk("no_key_req", 132'(key_req[i]), 132'(0));
        end
        if (wait_done) begin
            g = 0;
            while ((sb[i].size() != 0 || out_valid[i]) && g < 300) begin
                step(1);
                g++;
            end
            if (g >= 300) begin
                n_cmp++;
                n_err++;
                $display("FAIL drain_wait dut%0d: %0d words outstanding, expected 0", i, sb[i].size());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, b, rq, g;
        logic [127:0] st, key;
        logic [3:0]   hdr;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            key_ack[i]   = 1'b0;
            key_data[i]  = '0;
            out_ready[i] = 1'b1;
            err_cnt[i] = 0; req_cnt[i] = 0; exp_err[i] = 0; err_cyc[i] = 0; hs_cyc[i] = 0;
        end
        rst = 1'b1;
        step(3);
        // reset state
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", 132'(in_ready[i]), 132'(1));
            chk("rst_key_req", 132'(key_req[i]), 132'(0));
            chk("rst_key_round", 132'(key_round[i]), 132'(0));
            chk("rst_out_valid", 132'(out_valid[i]), 132'(0));
            chk("rst_out_data", out_data[i], '0);
            chk("rst_key_err", 132'(key_err[i]), 132'(0));
        end
        rst = 1'b0;
        step(2);

        // Basic XOR, one word per cycle
        st  = 128'h00112233_44556677_8899aabb_ccddeeff;
        key = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        send(0, 4'h3, st, key, 0, 1'b1, acc);
        chk("t1_handshake_cycle", 132'(hs_cyc[0]), 132'(acc + 5));
        chk("t1_ready_cycle", 132'(cyc), 132'(acc + 6));
        chk("t1_in_ready", 132'(in_ready[0]), 132'(1));

        // Key arriving 5 cycles late
        send(0, 4'h7, rnd128(), rnd128(), 5, 1'b1, acc);

        // Key never arriving
        b = err_cnt[0]; rq = req_cnt[0];
        send(0, 4'h6, rnd128(), rnd128(), -1, 1'b0, acc);
        step(KT + 3);
        chk("to_err_count", 132'(err_cnt[0] - b), 132'(1));
        chk("to_err_cycle", 132'(err_cyc[0]), 132'(acc + KT));
        chk("to_req_cycles", 132'(req_cnt[0] - rq), 132'(KT));
        chk("to_in_ready", 132'(in_ready[0]), 132'(1));

        // Bubble
        b = err_cnt[0]; rq = req_cnt[0];
        send(0, 4'h0, rnd128(), rnd128(), 0, 1'b1, acc);
        step(3);
        chk("bubble_err", 132'(err_cnt[0] - b), 132'(0));
        chk("bubble_req", 132'(req_cnt[0] - rq), 132'(0));

        // Illegal header
        b = err_cnt[0]; rq = req_cnt[0];
        send(0, 4'hB, rnd128(), rnd128(), 0, 1'b1, acc);
        chk("bad_in_ready", 132'(in_ready[0]), 132'(1));
        step(3);
        chk("bad_err_count", 132'(err_cnt[0] - b), 132'(1));
        chk("bad_err_cycle", 132'(err_cyc[0]), 132'(acc));
        chk("bad_req", 132'(req_cnt[0] - rq), 132'(0));

        // Backpressure for 10 cycles in OUT
        out_ready[0] = 1'b0;
        send(0, 4'h5, rnd128(), rnd128(), 0, 1'b0, acc);
        g = 0;
        while (!out_valid[0] && g < 30) begin
            step(1);
            g++;
        end
        chk("bp_reached_out", 132'(out_valid[0]), 132'(1));
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("bp_in_ready_low", 132'(in_ready[0]), 132'(0));
            chk("bp_valid_held", 132'(out_valid[0]), 132'(1));
        end
        out_ready[0] = 1'b1;
        step(1);
        chk("bp_valid_drop", 132'(out_valid[0]), 132'(0));
        chk("bp_in_ready_back", 132'(in_ready[0]), 132'(1));
        chk("bp_sb_empty", 132'(sb[0].size()), 132'(0));
        step(2);

        // Asynchronous reset during XOR
        send(0, 4'h9, rnd128(), rnd128(), 0, 1'b0, acc);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_key_req", 132'(key_req[0]), 132'(0));
        chk("arst_out_valid", 132'(out_valid[0]), 132'(0));
        chk("arst_out_data", out_data[0], '0);
        chk("arst_key_err", 132'(key_err[0]), 132'(0));
        chk("arst_key_round", 132'(key_round[0]), 132'(0));
        chk("arst_in_ready", 132'(in_ready[0]), 132'(1));
        sb[0].delete();
        step(2);
        rst = 1'b0;
        step(1);
        send(0, 4'h2, rnd128(), rnd128(), 1, 1'b1, acc);
        step(4);

        // Four words per cycle: same vector, then back-to-back words
        send(1, 4'h3, st, key, 0, 1'b1, acc);
        chk("w4_handshake_cycle", 132'(hs_cyc[1]), 132'(acc + 2));
        send(1, 4'hA, rnd128(), rnd128(), 0, 1'b0, acc);
        send(1, 4'h1, rnd128(), rnd128(), 0, 1'b1, acc2);
        chk("w4_back_to_back", 132'(acc2), 132'(acc + 4));
        send(0, 4'h4, rnd128(), rnd128(), 0, 1'b0, acc);
        send(0, 4'h8, rnd128(), rnd128(), 2, 1'b1, acc2);
        chk("w1_back_to_back", 132'(acc2), 132'(acc + 7));

        // Random traffic with random backpressure
        rand_rdy = 1'b1;
        for (int r = 0; r < 40; r++) begin
            hdr = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) != 0) hdr = 4'($urandom_range(1, NR));
            send(r % 2, hdr, rnd128(), rnd128(), int'($urandom_range(0, 3)), 1'b1, acc);
        end
        rand_rdy = 1'b0;
        step(1);
        out_ready[0] = 1'b1;
        out_ready[1] = 1'b1;
        step(5);

        for (int i = 0; i < 2; i++) begin
            chk("final_err_total", 132'(err_cnt[i]), 132'(exp_err[i]));
            chk("final_sb_empty", 132'(sb[i].size()), 132'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
